// File: rtl/sbox_fwd_word.sv
// Forward AES S-box on every byte of a word, elastic valid/ready pipeline.
// SBOX_FWD_MID_PIPE_EN adds a register between GF(2^4) inversion and the bottom linear layer (S=2).

// Top linear layer plus GF(2^4) inversion; the inverse nibble and the
// linear terms reused by the bottom multiplications are exported.
module sbox_fwd_top (
  input  logic [7:0]  x_i,
  output logic [3:0]  inv_o,
  output logic [17:0] lin_o
);
  logic u0, u1, u2, u3, u4, u5, u6, u7;
  logic t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13, t14;
  logic t15, t16, t17, t18, t19, t20, t21, t22, t23, t24, t25, t26, t27;
  logic m1, m2, m3, m4, m5, m6, m7, m8, m9, m10, m11, m12, m13, m14, m15;
  logic m16, m17, m18, m19, m20, m21, m22, m23, m24, m25, m26, m27, m28;
  logic m29, m30, m31, m32, m33, m34, m35, m36, m37, m38, m39, m40;

  assign {u0, u1, u2, u3, u4, u5, u6, u7} = x_i;

  assign t1  = u0 ^ u3;   assign t2  = u0 ^ u5;   assign t3  = u0 ^ u6;
  assign t4  = u3 ^ u5;   assign t5  = u4 ^ u6;   assign t6  = t1 ^ t5;
  assign t7  = u1 ^ u2;   assign t8  = u7 ^ t6;   assign t9  = u7 ^ t7;
  assign t10 = t6 ^ t7;   assign t11 = u1 ^ u5;   assign t12 = u2 ^ u5;
  assign t13 = t3 ^ t4;   assign t14 = t6 ^ t11;  assign t15 = t5 ^ t11;
  assign t16 = t5 ^ t12;  assign t17 = t9 ^ t16;  assign t18 = u3 ^ u7;
  assign t19 = t7 ^ t18;  assign t20 = t1 ^ t19;  assign t21 = u6 ^ u7;
  assign t22 = t7 ^ t21;  assign t23 = t2 ^ t22;  assign t24 = t2 ^ t10;
  assign t25 = t20 ^ t17; assign t26 = t3 ^ t16;  assign t27 = t1 ^ t12;

  assign m1  = t13 & t6;  assign m2  = t23 & t8;  assign m3  = t14 ^ m1;
  assign m4  = t19 & u7;  assign m5  = m4 ^ m1;   assign m6  = t3 & t16;
  assign m7  = t22 & t9;  assign m8  = t26 ^ m6;  assign m9  = t20 & t17;
  assign m10 = m9 ^ m6;   assign m11 = t1 & t15;  assign m12 = t4 & t27;
  assign m13 = m12 ^ m11; assign m14 = t2 & t10;  assign m15 = m14 ^ m11;
  assign m16 = m3 ^ m2;   assign m17 = m5 ^ t24;  assign m18 = m8 ^ m7;
  assign m19 = m10 ^ m15; assign m20 = m16 ^ m13; assign m21 = m17 ^ m15;
  assign m22 = m18 ^ m13; assign m23 = m19 ^ t25; assign m24 = m22 ^ m23;
  // GF(2^4) inversion core
  assign m25 = m22 & m20; assign m26 = m21 ^ m25; assign m27 = m20 ^ m21;
  assign m28 = m23 ^ m25; assign m29 = m28 & m27; assign m30 = m26 & m24;
  assign m31 = m20 & m23; assign m32 = m27 & m31; assign m33 = m27 ^ m25;
  assign m34 = m21 & m22; assign m35 = m24 & m34; assign m36 = m24 ^ m25;
  assign m37 = m21 ^ m29; assign m38 = m32 ^ m33; assign m39 = m23 ^ m30;
  assign m40 = m35 ^ m36;

  assign inv_o = {m40, m39, m38, m37};
  assign lin_o = {t6, t8, u7, t16, t9, t17, t15, t27, t10, t13, t23, t19,
                  t3, t22, t20, t1, t4, t2};
endmodule

// Bottom multiplications and output linear layer (affine constant folded into xnors).
module sbox_fwd_bot (
  input  logic [3:0]  inv_i,
  input  logic [17:0] lin_i,
  output logic [7:0]  y_o
);
  logic m37, m38, m39, m40, m41, m42, m43, m44, m45;
  logic t6, t8, u7, t16, t9, t17, t15, t27, t10, t13, t23, t19, t3, t22, t20, t1, t4, t2;
  logic m46, m47, m48, m49, m50, m51, m52, m53, m54, m55, m56, m57, m58, m59, m60, m61, m62, m63;
  logic l0, l1, l2, l3, l4, l5, l6, l7, l8, l9, l10, l11, l12, l13, l14;
  logic l15, l16, l17, l18, l19, l20, l21, l22, l23, l24, l25, l26, l27, l28, l29;
  logic s0, s1, s2, s3, s4, s5, s6, s7;

  assign {m40, m39, m38, m37} = inv_i;
  assign {t6, t8, u7, t16, t9, t17, t15, t27, t10, t13, t23, t19,
          t3, t22, t20, t1, t4, t2} = lin_i;

  assign m41 = m38 ^ m40; assign m42 = m37 ^ m39; assign m43 = m37 ^ m38;
  assign m44 = m39 ^ m40; assign m45 = m42 ^ m41;

  assign m46 = m44 & t6;  assign m47 = m40 & t8;  assign m48 = m39 & u7;
  assign m49 = m43 & t16; assign m50 = m38 & t9;  assign m51 = m37 & t17;
  assign m52 = m42 & t15; assign m53 = m45 & t27; assign m54 = m41 & t10;
  assign m55 = m44 & t13; assign m56 = m40 & t23; assign m57 = m39 & t19;
  assign m58 = m43 & t3;  assign m59 = m38 & t22; assign m60 = m37 & t20;
  assign m61 = m42 & t1;  assign m62 = m45 & t4;  assign m63 = m41 & t2;

  assign l0  = m61 ^ m62; assign l1  = m50 ^ m56; assign l2  = m46 ^ m48;
  assign l3  = m47 ^ m55; assign l4  = m54 ^ m58; assign l5  = m49 ^ m61;
  assign l6  = m62 ^ l5;  assign l7  = m46 ^ l3;  assign l8  = m51 ^ m59;
  assign l9  = m52 ^ m53; assign l10 = m53 ^ l4;  assign l11 = m60 ^ l2;
  assign l12 = m48 ^ m51; assign l13 = m50 ^ l0;  assign l14 = m52 ^ m61;
  assign l15 = m55 ^ l1;  assign l16 = m56 ^ l0;  assign l17 = m57 ^ l1;
  assign l18 = m58 ^ l8;  assign l19 = m63 ^ l4;  assign l20 = l0 ^ l1;
  assign l21 = l1 ^ l7;   assign l22 = l3 ^ l12;  assign l23 = l18 ^ l2;
  assign l24 = l15 ^ l9;  assign l25 = l6 ^ l10;  assign l26 = l7 ^ l9;
  assign l27 = l8 ^ l10;  assign l28 = l11 ^ l14; assign l29 = l11 ^ l17;

  assign s0 = l6 ^ l24;     assign s1 = ~(l16 ^ l26);
  assign s2 = ~(l19 ^ l28); assign s3 = l6 ^ l21;
  assign s4 = l20 ^ l22;    assign s5 = l25 ^ l29;
  assign s6 = ~(l13 ^ l27); assign s7 = ~(l6 ^ l23);

  assign y_o = {s0, s1, s2, s3, s4, s5, s6, s7};
endmodule

module sbox_fwd_word #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                out_last,
  output logic                busy
);
  logic [NBYTES-1:0][3:0]  inv;
  logic [NBYTES-1:0][17:0] lin;
  logic [NBYTES-1:0][7:0]  data_d;
  logic [NBYTES-1:0][7:0]  data_q;
  logic                    last_q, vout_q;
  logic                    rdy_out;

  assign rdy_out   = !vout_q | out_ready;
  assign out_valid = vout_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

`ifdef SBOX_FWD_MID_PIPE_EN
  logic [NBYTES-1:0][3:0]  inv_q;
  logic [NBYTES-1:0][17:0] lin_q;
  logic                    vmid_q, lmid_q;

  assign in_ready = !vmid_q | rdy_out;
  assign busy     = vmid_q | vout_q;

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    sbox_fwd_top u_top (.x_i(in_data[8*k +: 8]), .inv_o(inv[k]), .lin_o(lin[k]));
    sbox_fwd_bot u_bot (.inv_i(inv_q[k]), .lin_i(lin_q[k]), .y_o(data_d[k]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vmid_q <= 1'b0;
      lmid_q <= 1'b0;
      inv_q  <= '0;
      lin_q  <= '0;
      vout_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (in_ready) vmid_q <= in_valid;
      if (in_valid && in_ready) begin
        inv_q  <= inv;
        lin_q  <= lin;
        lmid_q <= in_last;
      end
      if (rdy_out) vout_q <= vmid_q;
      if (vmid_q && rdy_out) begin
        data_q <= data_d;
        last_q <= lmid_q;
      end
    end
  end
`else
  assign in_ready = rdy_out;
  assign busy     = vout_q;

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    sbox_fwd_top u_top (.x_i(in_data[8*k +: 8]), .inv_o(inv[k]), .lin_o(lin[k]));
    sbox_fwd_bot u_bot (.inv_i(inv[k]), .lin_i(lin[k]), .y_o(data_d[k]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vout_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (rdy_out) vout_q <= in_valid;
      // payload only moves on an accepted transfer, so idle in_data never reaches out_data
      if (in_valid && rdy_out) begin
        data_q <= data_d;
        last_q <= in_last;
      end
    end
  end
`endif
endmodule

// File: tb/tb_sbox_fwd_word.sv
// Bench for sbox_fwd_word: S-box model from GF(2^8) arithmetic, queue scoreboard, both builds.
module tb_sbox_fwd_word;
`ifdef SBOX_FWD_MID_PIPE_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [31:0] in_data = '0, out_data;
  logic        out_valid, out_ready = 1'b0, out_last, busy;

  int nrun = 0, nfail = 0;
  logic [7:0] stab [256];
  logic [7:0] itab [256];

  typedef struct packed { logic last; logic [31:0] din; } item_t;
  item_t q[$];

  sbox_fwd_word #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] inv, r;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (v != 0 && gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
    r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
    return r ^ 8'h63;
  endfunction

  function automatic logic [31:0] sbw(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = stab[w[8*k +: 8]];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nrun++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
    end
    nrun++;
    if (out_data !== 32'h0 || out_last !== 1'b0) begin
      nfail++;
      $display("FAIL reset_payload: out_data=%h out_last=%b, want 0 0", out_data, out_last);
    end
  endtask

  task automatic test_kat();
    logic [31:0] w, e;
    int lat;
    bit got;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      w = (i == 0) ? 32'h000153ff : 32'h02030410;
      e = (i == 0) ? 32'h637ced16 : 32'h777bf2ca;
      in_valid = 1'b1; in_data = w; in_last = i[0]; out_ready = 1'b1;
      lat = 0; got = 1'b0;
      while (!got && lat < 8) begin
        @(posedge clk); lat++;
        #1 in_valid = 1'b0; in_data = 'x;
        @(negedge clk);
        if (out_valid) got = 1'b1;
      end
      nrun++;
      if (!got || lat != S) begin
        nfail++;
        $display("FAIL kat_latency[%0d]: got=%0b cycles=%0d, want %0d", i, got, lat, S);
      end
      nrun++;
      if (out_data !== e || out_last !== i[0]) begin
        nfail++;
        $display("FAIL kat_data[%0d]: out=%h last=%b, want %h %b", i, out_data, out_last, e, i[0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    int sent, recv, cyc;
    item_t it;
    sent = 0; recv = 0; cyc = 0;
    q.delete();
    out_ready = 1'b1;
    while (recv < 256 && cyc < 400) begin
      if (sent < 256) begin
        in_valid = 1'b1; in_last = sent[0];
        in_data = {8'(sent + 3), 8'(sent + 2), 8'(sent + 1), 8'(sent)};
      end else begin
        in_valid = 1'b0; in_data = 'x;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        it = (q.size() > 0) ? q.pop_front() : '0;
        nrun++;
        if (out_data !== sbw(it.din) || out_last !== it.last) begin
          nfail++;
          $display("FAIL exh_data[%0d]: out=%h last=%b, want %h %b", recv, out_data, out_last, sbw(it.din), it.last);
        end
        nrun++;
        if ({itab[out_data[31:24]], itab[out_data[23:16]], itab[out_data[15:8]], itab[out_data[7:0]]} !== it.din) begin
          nfail++;
          $display("FAIL exh_inverse[%0d]: out=%h does not invert to %h", recv, out_data, it.din);
        end
        recv++;
      end
      if (in_valid) begin
        nrun++;
        if (in_ready !== 1'b1) begin
          nfail++;
          $display("FAIL exh_throughput: in_ready=%b at word %0d, want 1", in_ready, sent);
        end else begin
          q.push_back('{last: in_last, din: in_data});
          sent++;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    nrun++;
    if (recv != 256 || cyc != 256 + S) begin
      nfail++;
      $display("FAIL exh_count: recv=%0d cycles=%0d, want 256 %0d", recv, cyc, 256 + S);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_d [2];
    logic        got_l [2];
    int n;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h01010101; in_last = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bit acc;
      @(negedge clk);
      if (c >= 3) begin
        nrun++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h63636363 || out_last !== 1'b0) begin
          nfail++;
          $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b out=%h last=%b, want 0 1 63636363 0",
                   c, in_ready, out_valid, out_data, out_last);
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    n = 0;
    got_d[0] = '0; got_d[1] = '0; got_l[0] = 1'b0; got_l[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      @(negedge clk);
      if (out_valid) begin
        if (n < 2) begin got_d[n] = out_data; got_l[n] = out_last; end
        n++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    nrun++;
    if (n != 2 || got_d[0] !== 32'h63636363 || got_l[0] !== 1'b0 ||
        got_d[1] !== 32'h7c7c7c7c || got_l[1] !== 1'b1) begin
      nfail++;
      $display("FAIL bp_release: n=%0d w0=%h/%b w1=%h/%b, want 2 63636363/0 7c7c7c7c/1",
               n, got_d[0], got_l[0], got_d[1], got_l[1]);
    end
  endtask

  task automatic test_random();
    item_t it;
    int errs;
    errs = 0;
    q.delete();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit acc;
      if (!in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1; in_data = $urandom; in_last = $urandom_range(0, 1) != 0;
        end else begin
          in_data = 'x;
        end
      end
      out_ready = (cyc % 2000 < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        nrun++;
        if (q.size() == 0) begin
          nfail++;
          if (errs++ < 10) $display("FAIL rand_spurious: out=%h with empty scoreboard", out_data);
        end else begin
          it = q.pop_front();
          if (out_data !== sbw(it.din) || out_last !== it.last) begin
            nfail++;
            if (errs++ < 10)
              $display("FAIL rand_data: out=%h last=%b, want %h %b", out_data, out_last, sbw(it.din), it.last);
          end
        end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back('{last: in_last, din: in_data});
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        nrun++;
        it = (q.size() > 0) ? q.pop_front() : '0;
        if (out_data !== sbw(it.din) || out_last !== it.last) begin
          nfail++;
          $display("FAIL rand_drain: out=%h last=%b, want %h %b", out_data, out_last, sbw(it.din), it.last);
        end
      end
      @(posedge clk); #1;
    end
    nrun++;
    if (q.size() != 0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL rand_lost: %0d words missing busy=%b, want 0 0", q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int acc, n;
    acc = 0; n = 0;
    out_ready = 1'b0;
    while (acc < S && n < 10) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; in_data = $urandom;
    @(negedge clk);
    nrun++;
    if (acc != S || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
      nfail++;
      $display("FAIL full_stall: accepted=%0d in_ready=%b busy=%b out_valid=%b, want %0d 0 1 1",
               acc, in_ready, busy, out_valid, S);
    end
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_data = 'x;
    @(negedge clk);
    nrun++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_last !== 1'b0) begin
      nfail++;
      $display("FAIL rst_mid: out_valid=%b busy=%b in_ready=%b out=%h last=%b, want 0 0 1 0 0",
               out_valid, busy, in_ready, out_data, out_last);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      nrun++;
      if (out_valid !== 1'b0) begin
        nfail++;
        $display("FAIL rst_stale[%0d]: out_valid=%b out=%h, want 0", c, out_valid, out_data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) stab[i] = sbox_ref(8'(i));
    for (int i = 0; i < 256; i++) itab[stab[i]] = 8'(i);
    test_reset();
    test_kat();
    test_exhaustive();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
